// File: rtl/param_fifo_v.sv
// Parameterised first-word-fall-through FIFO.
// Sticky overflow/underflow flags; synchronous active-high reset.
module param_fifo_v #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [W-1:0]         i_d_in,
    input  logic                 i_rd_en,
    output logic [W-1:0]         o_d_out,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [$clog2(D):0]   o_count,
    output logic                 o_ovf,
    output logic                 o_udf
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    assign w_full   = (r_count == CW'(D));
    assign w_empty  = (r_count == '0);
    // A read frees a slot in the same edge, so a full FIFO still takes a write.
    assign w_wr_acc = i_wr_en & (~w_full | i_rd_en);
    assign w_rd_acc = i_rd_en & ~w_empty;

    // Storage is deliberately not reset; empty hides stale words.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr_acc) begin
            r_mem[r_wp] <= i_d_in;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr_en && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (i_rd_en && !w_rd_acc) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Head word falls through; forced to zero while empty.
    always_comb begin
        o_d_out = '0;
        if (!w_empty) begin
            o_d_out = r_mem[r_rp];
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: tb/tb_param_fifo_v.sv
// Directed bench for param_fifo_v (W=8, D=4).
// Queue model checked every cycle plus literal expectations.
module tb_param_fifo_v;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] d_in = '0;
    logic [W-1:0] d_out;
    logic         full;
    logic         empty;
    logic [2:0]   count;
    logic         ovf;
    logic         udf;

    int n_checks = 0;
    int n_fails  = 0;

    param_fifo_v #(.W(W), .D(D)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_wr_en (wr_en),
        .i_d_in  (d_in),
        .i_rd_en (rd_en),
        .o_d_out (d_out),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count),
        .o_ovf   (ovf),
        .o_udf   (udf)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of stored words and two flags.
    logic [W-1:0] q [$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        bit was_full;
        bit was_empty;
        bit wa;
        bit ra;
        if (reset) begin
            q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            chk_en = 1'b1;
        end else begin
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            wa = wr_en && (!was_full || rd_en);
            ra = rd_en && !was_empty;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d_in);
            if (wr_en && !wa) m_ovf = 1'b1;
            if (rd_en && !ra) m_udf = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", int'(count), q.size());
            check("m_full", int'(full), int'(q.size() == D));
            check("m_empty", int'(empty), int'(q.size() == 0));
            check("m_dout", int'(d_out),
                  (q.size() == 0) ? 0 : int'(q[0]));
            check("m_ovf", int'(ovf), int'(m_ovf));
            check("m_udf", int'(udf), int'(m_udf));
        end
    end

    task automatic step(input logic rst, input logic wr,
                        input logic rd, input logic [W-1:0] d);
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        d_in  = d;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    logic [W-1:0] seq [4];

    initial begin
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        seq[3] = 8'h44;

        // Reset held 7 cycles while a write is requested.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'hAA);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_dout", int'(d_out), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_udf", int'(udf), 0);

        // Fill, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, seq[i]);
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_dout", int'(d_out), int'(seq[i]));
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check("drain_empty", int'(empty), 1);
        check("drain_udf", int'(udf), 0);

        // Write while full is rejected and leaves contents intact.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, seq[i]);
        step(1'b0, 1'b1, 1'b0, 8'h55);
        check("ovf_set", int'(ovf), 1);
        check("ovf_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            check("ovf_dout", int'(d_out), int'(seq[i]));
            step(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check("ovf_empty", int'(empty), 1);

        // Read and write together on an empty FIFO.
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        check("rw_empty_count", int'(count), 1);
        check("rw_empty_dout", int'(d_out), 8'h5A);
        check("rw_empty_udf", int'(udf), 1);

        // Fill up, then read+write while full across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        check("wrap_full", int'(full), 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'($urandom));
            check("wrap_count", int'(count), 4);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_empty", int'(empty), 1);

        // Read on empty leaves things alone apart from udf.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("udf_empty_count", int'(count), 0);

        // Mid-operation reset discards contents.
        step(1'b0, 1'b1, 1'b0, 8'hC1);
        step(1'b0, 1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        check("mid_rst_dout", int'(d_out), 8'h77);
        check("mid_rst_count", int'(count), 1);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_udf", int'(udf), 0);

        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
